// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB control FSM around an
// internal register file and ALU. Define BRANCH_EXT_EN to also decode BNE/BLT/BGE.
module multicycle_core #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter int              IMEM_AW  = 10,
  parameter int              DMEM_AW  = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic               dmem_we,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    wb_data,
  output logic [3:0]         status,
  output logic               retire,
  output logic               halted
);

  localparam int         RW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NREG_L = 6'(NREG);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // Branch ops are numbered last so "is a branch" is a single compare.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
`ifdef BRANCH_EXT_EN
  localparam logic [3:0] OP_BNE  = 4'd10;
  localparam logic [3:0] OP_BLT  = 4'd11;
  localparam logic [3:0] OP_BGE  = 4'd12;
`endif

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [2:0]      state;
  logic [31:0]     ir_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
  logic [XLEN-1:0] regs [NREG];

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext13(input logic [12:0] v);
    return {{(XLEN-13){v[12]}}, v};
  endfunction

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic [3:0]      dec_op;
  logic            dec_legal, use_rd, use_rs2;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_op    = OP_ADD;
    dec_legal = 1'b0;
    use_rd    = 1'b0;
    use_rs2   = 1'b0;
    dec_imm   = sext12(ir_q[31:20]);
    case (opcode)
      OPC_R: begin
        use_rd    = 1'b1;
        use_rs2   = 1'b1;
        dec_legal = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'h0}: dec_op = OP_ADD;
          {7'h20, 3'h0}: dec_op = OP_SUB;
          {7'h00, 3'h2}: dec_op = OP_SLT;
          {7'h00, 3'h4}: dec_op = OP_XOR;
          {7'h00, 3'h6}: dec_op = OP_OR;
          {7'h00, 3'h7}: dec_op = OP_AND;
          default:       dec_legal = 1'b0;
        endcase
      end
      OPC_IMM: begin
        use_rd    = 1'b1;
        dec_op    = OP_ADDI;
        dec_legal = (funct3 == 3'h0);
      end
      OPC_LOAD: begin
        use_rd    = 1'b1;
        dec_op    = OP_LW;
        dec_legal = (funct3 == 3'h2);
      end
      OPC_STORE: begin
        use_rs2   = 1'b1;
        dec_op    = OP_SW;
        dec_imm   = sext12({ir_q[31:25], ir_q[11:7]});
        dec_legal = (funct3 == 3'h2);
      end
      OPC_BRANCH: begin
        use_rs2   = 1'b1;
        dec_imm   = sext13({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0});
        dec_legal = 1'b1;
        case (funct3)
          3'h0:    dec_op = OP_BEQ;
`ifdef BRANCH_EXT_EN
          3'h1:    dec_op = OP_BNE;
          3'h4:    dec_op = OP_BLT;
          3'h5:    dec_op = OP_BGE;
`endif
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
    // Reduced register files (RV32E) trap on any out-of-range index actually used.
    if (({1'b0, rs1} >= NREG_L) || (use_rs2 && ({1'b0, rs2} >= NREG_L)) ||
        (use_rd && ({1'b0, rd} >= NREG_L)))
      dec_legal = 1'b0;
  end

  logic [XLEN-1:0] op2, alu_res;
  logic [XLEN:0]   sum, dif;
  logic            fl_n, fl_z, fl_c, fl_v;

  always_comb begin
    op2 = ((op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW)) ? imm_q : b_q;
    sum = {1'b0, a_q} + {1'b0, op2};
    dif = {1'b0, a_q} - {1'b0, op2};
    alu_res = '0;
    fl_c    = 1'b0;
    fl_v    = 1'b0;
    case (op_q)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: begin
        alu_res = sum[XLEN-1:0];
        fl_c    = sum[XLEN];
        fl_v    = (a_q[XLEN-1] == op2[XLEN-1]) && (alu_res[XLEN-1] != a_q[XLEN-1]);
      end
      OP_AND: alu_res = a_q & op2;
      OP_OR:  alu_res = a_q | op2;
      OP_XOR: alu_res = a_q ^ op2;
      OP_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(op2))};
      default: begin
        alu_res = dif[XLEN-1:0];
        fl_c    = ~dif[XLEN];
        fl_v    = (a_q[XLEN-1] != op2[XLEN-1]) && (alu_res[XLEN-1] != a_q[XLEN-1]);
      end
    endcase
    fl_n = alu_res[XLEN-1];
    fl_z = (alu_res == '0);
  end

  logic is_branch, take;
  assign is_branch = (op_q >= OP_BEQ);

  always_comb begin
    take = fl_z;
`ifdef BRANCH_EXT_EN
    case (op_q)
      OP_BNE:  take = ~fl_z;
      OP_BLT:  take = fl_n ^ fl_v;
      OP_BGE:  take = ~(fl_n ^ fl_v);
      default: take = fl_z;
    endcase
`endif
  end

  logic [XLEN-1:0] pc_plus4, wb_val;
  assign pc_plus4 = pc + XLEN'(4);
  assign wb_val   = (op_q == OP_LW) ? mdr_q : alu_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir_q    <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      wb_data <= '0;
      status  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (run) begin
            ir_q  <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!dec_legal) begin
            state <= S_HALT;
          end else begin
            a_q   <= regs[rs1[RW-1:0]];
            b_q   <= regs[rs2[RW-1:0]];
            imm_q <= dec_imm;
            op_q  <= dec_op;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_q  <= alu_res;
          status <= {fl_n, fl_z, fl_c, fl_v};
          if (is_branch) begin
            pc    <= take ? (pc + imm_q) : pc_plus4;
            state <= S_FETCH;
          end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (op_q == OP_LW) begin
            mdr_q <= dmem_rdata;
            state <= S_WB;
          end else begin
            pc    <= pc_plus4;
            state <= S_FETCH;
          end
        end
        S_WB: begin
          wb_data <= wb_val;
          pc      <= pc_plus4;
          state   <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  // x0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if ((state == S_WB) && (rd != 5'd0)) begin
      regs[rd[RW-1:0]] <= wb_val;
    end
  end

  assign imem_addr  = pc[IMEM_AW+1:2];
  assign dmem_addr  = alu_q[DMEM_AW+1:2];
  assign dmem_wdata = b_q;
  assign dmem_we    = (state == S_MEM) && (op_q == OP_SW);
  assign retire     = (state == S_WB) || ((state == S_EXEC) && is_branch) ||
                      ((state == S_MEM) && (op_q == OP_SW));
  assign halted     = (state == S_HALT);

endmodule
